// File: rtl/sp_pkg.sv
// Shared types and constants for the sample-packet transmit controller.
package sp_pkg;

   localparam int unsigned DATA_W             = 16;
   localparam int unsigned SEQ_W              = 32;
   localparam int unsigned WCNT_W             = 10;
   localparam int unsigned HDR_WORDS          = 2;
   localparam int unsigned DEF_WORDS_PER_PKT  = 512;
   localparam int unsigned DEF_PKTS_PER_BLOCK = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_GAP
   } sp_state_e;

   // One word on the transmit bus with its packet-framing sidebands.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
   } sp_word_t;

endpackage

// File: rtl/sp_xmit_ctrl_if.sv
// Transmit-slot arbitration and valid/ready word stream towards the Ethernet side.
interface sp_xmit_ctrl_if;

   logic                      tx_req;
   logic                      tx_grant;
   logic [sp_pkg::DATA_W-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   logic                      tx_sop;
   logic                      tx_eop;

   modport master (
      output tx_req, tx_data, tx_valid, tx_sop, tx_eop,
      input  tx_grant, tx_ready
   );

   modport slave (
      input  tx_req, tx_data, tx_valid, tx_sop, tx_eop,
      output tx_grant, tx_ready
   );

endinterface

// File: rtl/sp_out_reg.sv
// Single-entry valid/ready output register carrying a word and its sop/eop flags.
module sp_out_reg
   import sp_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     load,
   input  sp_word_t din,
   input  logic     ready,
   output sp_word_t q,
   output logic     valid,
   output logic     can_load_c
);

   // Register may take a new word when empty or when its current word leaves this cycle.
   assign can_load_c = !valid || ready;

   // Load a new word, or drop valid once the held word has been accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load && can_load_c) begin
         q     <= din;
         valid <= 1'b1;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sp_xmit_ctrl.sv
// Drains a completed SP_fifo block as PKTS_PER_BLOCK packets of two header words
// (sequence number) followed by WORDS_PER_PKT sample words.
module sp_xmit_ctrl
   import sp_pkg::*;
#(
   parameter int unsigned WORDS_PER_PKT  = DEF_WORDS_PER_PKT,
   parameter int unsigned PKTS_PER_BLOCK = DEF_PKTS_PER_BLOCK
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              have_sp_data,
   input  logic              sp_fifo_rdempty,
   input  logic [DATA_W-1:0] sp_fifo_rddata,
   output logic              sp_fifo_rdreq,
   sp_xmit_ctrl_if.master    tx,
   output logic [SEQ_W-1:0]  seq_num,
   output logic              busy,
   output logic              sp_underrun
);

   localparam int unsigned PKT_W = $clog2(PKTS_PER_BLOCK + 1);

   sp_state_e         state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [PKT_W-1:0]  pkt_q, pkt_d;
   logic [SEQ_W-1:0]  seq_d;
   logic              underrun_d;
   logic              tx_req_q;
   logic              load_c;
   logic              can_load_c;
   logic              eop_acc_c;
   sp_word_t          word_c;
   sp_word_t          out_q;
   logic              out_valid;

   assign eop_acc_c   = out_valid && tx.tx_ready && out_q.eop;
   assign tx.tx_req   = tx_req_q;
   assign tx.tx_data  = out_q.data;
   assign tx.tx_sop   = out_q.sop;
   assign tx.tx_eop   = out_q.eop;
   assign tx.tx_valid = out_valid;

   // Next-state, counter updates and the word offered to the output register.
   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      pkt_d         = pkt_q;
      seq_d         = seq_num;
      underrun_d    = sp_underrun;
      load_c        = 1'b0;
      sp_fifo_rdreq = 1'b0;
      word_c        = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (have_sp_data) begin
               state_d    = ST_REQ;
               pkt_d      = '0;
               underrun_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (tx.tx_grant) state_d = ST_HDR0;
         end
         ST_HDR0: begin
            word_c.data = seq_num[31:16];
            word_c.sop  = 1'b1;
            load_c      = 1'b1;
            if (can_load_c) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            word_c.data = seq_num[15:0];
            load_c      = 1'b1;
            if (can_load_c) begin
               state_d = ST_DATA;
               wcnt_d  = '0;
            end
         end
         ST_DATA: begin
            if (wcnt_q < WCNT_W'(WORDS_PER_PKT)) begin
               word_c.data = sp_fifo_rddata;
               word_c.eop  = (wcnt_q == WCNT_W'(WORDS_PER_PKT - 1));
               if (sp_fifo_rdempty) begin
                  underrun_d = 1'b1;
               end else begin
                  load_c = 1'b1;
                  // Show-ahead pop coincides with the output register load.
                  if (can_load_c) begin
                     sp_fifo_rdreq = 1'b1;
                     wcnt_d        = wcnt_q + WCNT_W'(1);
                  end
               end
            end else if (eop_acc_c) begin
               state_d = ST_GAP;
               pkt_d   = pkt_q + PKT_W'(1);
               seq_d   = seq_num + SEQ_W'(1);
            end
         end
         ST_GAP: begin
            state_d = (pkt_q < PKT_W'(PKTS_PER_BLOCK)) ? ST_REQ : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         pkt_q       <= '0;
         seq_num     <= '0;
         sp_underrun <= 1'b0;
         tx_req_q    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         pkt_q       <= pkt_d;
         seq_num     <= seq_d;
         sp_underrun <= underrun_d;
         tx_req_q    <= (state_d != ST_IDLE) && (state_d != ST_GAP);
         busy        <= (state_d != ST_IDLE);
      end
   end

   sp_out_reg u_out_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (load_c),
      .din        (word_c),
      .ready      (tx.tx_ready),
      .q          (out_q),
      .valid      (out_valid),
      .can_load_c (can_load_c)
   );

endmodule

// File: tb/tb_sp_xmit_ctrl.sv
// Bench for sp_xmit_ctrl: FIFO ramp source, simple arbiter, packet-stream model.
module tb_sp_xmit_ctrl;
   import sp_pkg::*;

   localparam int unsigned WORDS       = DEF_WORDS_PER_PKT;
   localparam int unsigned PKTS        = DEF_PKTS_PER_BLOCK;
   localparam int unsigned BLOCK_WORDS = WORDS * PKTS;
   localparam int unsigned PKT_LEN     = HDR_WORDS + WORDS;

   logic        clk = 1'b0;
   logic        reset;
   logic        have_sp_data;
   logic        sp_fifo_rdempty;
   logic [15:0] sp_fifo_rddata;
   logic        sp_fifo_rdreq;
   logic [31:0] seq_num;
   logic        busy;
   logic        sp_underrun;

   sp_xmit_ctrl_if bus ();

   sp_xmit_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .have_sp_data    (have_sp_data),
      .sp_fifo_rdempty (sp_fifo_rdempty),
      .sp_fifo_rddata  (sp_fifo_rddata),
      .sp_fifo_rdreq   (sp_fifo_rdreq),
      .tx              (bus),
      .seq_num         (seq_num),
      .busy            (busy),
      .sp_underrun     (sp_underrun)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // FIFO source: a block holds the ramp 0..BLOCK_WORDS-1, head word shown ahead.
   int unsigned head        = BLOCK_WORDS;
   logic        refill      = 1'b0;
   logic        force_empty = 1'b0;
   assign sp_fifo_rdempty = (head >= BLOCK_WORDS) || force_empty;
   assign sp_fifo_rddata  = 16'(head);

   always @(posedge clk) begin
      if (refill)             head <= 0;
      else if (sp_fifo_rdreq) head <= head + 1;
   end

   // Arbiter grants three cycles after a request; downstream ready is 100% or 30%.
   logic ready_rand  = 1'b0;
   logic grant_block = 1'b0;
   int   gnt_cnt     = 0;
   always @(posedge clk) begin
      #1;
      bus.tx_ready = ready_rand ? ($urandom_range(99, 0) < 30) : 1'b1;
      if (reset || !bus.tx_req) begin
         gnt_cnt      = 0;
         bus.tx_grant = 1'b0;
      end else if (!grant_block) begin
         if (gnt_cnt >= 3) bus.tx_grant = 1'b1;
         else              gnt_cnt++;
      end
   end

   // Packet-stream model: every packet is {seq hi, seq lo, WORDS ramp samples}.
   int unsigned exp_pos  = 0;
   logic [31:0] exp_seq  = 0;
   logic        prev_eop = 1'b0;
   int unsigned rd_cnt   = 0;
   int unsigned acc_cnt  = 0;
   int unsigned pkt_cnt  = 0;
   logic [15:0] first_pl = 16'hdead;
   logic [15:0] last_pl  = 16'hdead;
   logic [15:0] exp_data;
   logic        exp_sop;
   logic        exp_eop;

   always @(negedge clk) begin
      if (reset) begin
         exp_pos  = 0;
         exp_seq  = 0;
         prev_eop = 1'b0;
      end else begin
         if (prev_eop) chk("gap_tx_req_low", 32'(bus.tx_req), 32'd0);
         prev_eop = 1'b0;
         if (bus.tx_valid) chk("valid_needs_req", 32'(bus.tx_req), 32'd1);
         if (sp_fifo_rdreq) begin
            rd_cnt++;
            chk("rdreq_while_empty", 32'(sp_fifo_rdempty), 32'd0);
            chk("rdreq_without_load", 32'(!bus.tx_valid || bus.tx_ready), 32'd1);
         end
         if (bus.tx_valid && bus.tx_ready) begin
            exp_sop = (exp_pos == 0);
            exp_eop = (exp_pos == PKT_LEN - 1);
            if (exp_pos == 0)      exp_data = exp_seq[31:16];
            else if (exp_pos == 1) exp_data = exp_seq[15:0];
            else                   exp_data = 16'((exp_seq % PKTS) * WORDS + exp_pos - HDR_WORDS);
            chk("word_data", 32'(bus.tx_data), 32'(exp_data));
            chk("word_sop", 32'(bus.tx_sop), 32'(exp_sop));
            chk("word_eop", 32'(bus.tx_eop), 32'(exp_eop));
            acc_cnt++;
            if (exp_pos == HDR_WORDS && (exp_seq % PKTS) == 0) first_pl = bus.tx_data;
            if (exp_eop) begin
               last_pl  = bus.tx_data;
               exp_pos  = 0;
               exp_seq  = exp_seq + 1;
               prev_eop = 1'b1;
               pkt_cnt++;
            end else begin
               exp_pos++;
            end
         end
      end
   end

   task automatic start_block();
      refill = 1'b1;
      @(posedge clk); #1;
      refill       = 1'b0;
      have_sp_data = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) begin @(posedge clk); #1; end
      chk("busy_after_start", 32'(busy), 32'd1);
      have_sp_data = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) begin @(posedge clk); #1; end
      chk("busy_at_end", 32'(busy), 32'd0);
   endtask

   int unsigned rd0, acc0, pk0;

   task automatic snap();
      rd0  = rd_cnt;
      acc0 = acc_cnt;
      pk0  = pkt_cnt;
   endtask

   task automatic chk_block(input string tag, input logic [31:0] seq_exp);
      chk({tag, "_rdreq_pulses"}, 32'(rd_cnt - rd0), 32'd4096);
      chk({tag, "_words"}, 32'(acc_cnt - acc0), 32'd4112);
      chk({tag, "_packets"}, 32'(pkt_cnt - pk0), 32'd8);
      chk({tag, "_seq_num"}, seq_num, seq_exp);
      chk({tag, "_tx_req_low"}, 32'(bus.tx_req), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_req"}, 32'(bus.tx_req), 32'd0);
      chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
      chk({tag, "_tx_sop"}, 32'(bus.tx_sop), 32'd0);
      chk({tag, "_tx_eop"}, 32'(bus.tx_eop), 32'd0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      chk({tag, "_rdreq"}, 32'(sp_fifo_rdreq), 32'd0);
      chk({tag, "_seq_num"}, seq_num, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_underrun"}, 32'(sp_underrun), 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      have_sp_data = 1'b0;
      bus.tx_grant = 1'b0;
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Block 1: full-rate drain, seq 0..7.
      snap();
      start_block();
      wait_idle(6000);
      chk_block("blk1", 32'd8);
      chk("blk1_underrun", 32'(sp_underrun), 32'd0);
      chk("blk1_first_payload", 32'(first_pl), 32'h0000);
      chk("blk1_last_payload", 32'(last_pl), 32'h0fff);

      // Block 2: seq 8..15, FIFO empty for 20 cycles at payload word 100 of packet 3.
      snap();
      start_block();
      for (int i = 0; i < 4000 && head != 3 * WORDS + 100; i++) begin @(posedge clk); #1; end
      chk("stall_point_reached", head, 32'(3 * WORDS + 100));
      chk("underrun_before_stall", 32'(sp_underrun), 32'd0);
      force_empty = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         chk("stall_no_rdreq", 32'(sp_fifo_rdreq), 32'd0);
      end
      chk("stall_head_held", head, 32'(3 * WORDS + 100));
      chk("underrun_set", 32'(sp_underrun), 32'd1);
      force_empty = 1'b0;
      wait_idle(6000);
      chk_block("blk2", 32'd16);
      chk("blk2_underrun_sticky", 32'(sp_underrun), 32'd1);

      // Block 3: grant withheld 100 cycles, then 30% downstream ready.
      snap();
      grant_block = 1'b1;
      start_block();
      repeat (100) begin
         @(posedge clk); #1;
         chk("nogrant_tx_req", 32'(bus.tx_req), 32'd1);
         chk("nogrant_tx_valid", 32'(bus.tx_valid), 32'd0);
         chk("nogrant_rdreq", 32'(sp_fifo_rdreq), 32'd0);
      end
      grant_block = 1'b0;
      ready_rand  = 1'b1;
      wait_idle(30000);
      ready_rand  = 1'b0;
      chk_block("blk3", 32'd24);
      chk("blk3_underrun_cleared", 32'(sp_underrun), 32'd0);
      chk("blk3_first_payload", 32'(first_pl), 32'h0000);
      chk("blk3_last_payload", 32'(last_pl), 32'h0fff);

      // Block 4: reset after payload word 250 of packet 2 has gone out.
      start_block();
      for (int i = 0; i < 3000 && !(exp_seq == 32'd26 && exp_pos == HDR_WORDS + 250); i++) begin
         @(posedge clk); #1;
      end
      chk("reset_point_reached", 32'(exp_pos), 32'(HDR_WORDS + 250));
      reset = 1'b1;
      #1;
      chk_reset_outputs("midpkt_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Block 5: fresh block after reset restarts at seq 0.
      snap();
      start_block();
      wait_idle(6000);
      chk_block("blk5", 32'd8);
      chk("blk5_first_payload", 32'(first_pl), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
